// File: rtl/keycode_action_ctrl.sv
// keycode_action_ctrl
// Turns the raw USB HID keycode exported by the SoC into debounced game controls:
// - a debounced keycode for the hex display,
// - a movement enable and a facing direction,
// - a one-cycle sword-attack pulse with a frame-counted cooldown,
// - a pause toggle.
// Single clock domain (Clk) with a synchronous active-high reset (Reset).
module keycode_action_ctrl #(
  parameter int          STABLE_CYCLES   = 4,
  parameter int          ATTACK_COOLDOWN = 3,
  parameter logic [7:0]  KEY_UP          = 8'h1A,
  parameter logic [7:0]  KEY_DOWN        = 8'h16,
  parameter logic [7:0]  KEY_LEFT        = 8'h04,
  parameter logic [7:0]  KEY_RIGHT       = 8'h07,
  parameter logic [7:0]  KEY_ATTACK      = 8'h2C,
  parameter logic [7:0]  KEY_PAUSE       = 8'h28
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       frame_tick,
  output logic [7:0] key_stable,
  output logic       move_en,
  output logic [1:0] facing,
  output logic       attack_pulse,
  output logic       attack_busy,
  output logic       paused
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int CW = $clog2(ATTACK_COOLDOWN + 1);

  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CD_LOAD   = CW'(ATTACK_COOLDOWN);

  // Direction encodings of the facing output.
  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  typedef enum logic {
    IDLE,
    COOLDOWN
  } atk_state_t;

  // Input and debounce state.
  logic [7:0]    kc_q;
  logic [SW-1:0] stab_cnt;
  logic          stab_inc;

  // Press-event tracking.
  logic [7:0]    key_stable_d;
  logic          key_changed;
  logic          press_evt;
  logic [7:0]    press_code;
  logic          press_attack;
  logic          press_pause;

  // Direction decode.
  logic          dir_hit;
  logic [1:0]    dir_code;

  // Attack FSM state.
  atk_state_t    atk_state;
  logic [CW-1:0] cd_cnt;

  // The registered code counts as held for another cycle when the next
  // sample (the raw input) still matches it. This makes acceptance land
  // STABLE_CYCLES+1 cycles after the raw change, and any change before
  // acceptance restarts the count.
  always_comb begin
    stab_inc = (kc_q != key_stable) && (keycode == kc_q);
  end

  // key_stable moved on the previous edge, so a new key has just been accepted.
  // A release back to 8'h00 also raises this, but it matches no action code.
  always_comb begin
    key_changed  = (key_stable != key_stable_d);
    press_attack = press_evt && (press_code == KEY_ATTACK);
    press_pause  = press_evt && (press_code == KEY_PAUSE);
  end

  // Map the accepted code to a facing direction.
  // Unknown codes fall back to holding the current facing.
  always_comb begin
    dir_hit  = 1'b1;
    dir_code = facing;
    case (key_stable)
      KEY_UP:    dir_code = DIR_UP;
      KEY_DOWN:  dir_code = DIR_DOWN;
      KEY_LEFT:  dir_code = DIR_LEFT;
      KEY_RIGHT: dir_code = DIR_RIGHT;
      default:   dir_hit  = 1'b0;
    endcase
  end

  // Input register, debounce counter, accepted key and press-event capture.
  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      kc_q         <= 8'h00;
      stab_cnt     <= '0;
      key_stable   <= 8'h00;
      key_stable_d <= 8'h00;
      press_evt    <= 1'b0;
      press_code   <= 8'h00;
    end else begin
      kc_q         <= keycode;
      key_stable_d <= key_stable;
      // Latch the code together with the event, so the action logic sees
      // the key that caused it even if key_stable has moved on since.
      press_evt    <= key_changed;
      press_code   <= key_stable;
      if (stab_inc) begin
        if (stab_cnt == STAB_LAST) begin
          key_stable <= kc_q;
          stab_cnt   <= '0;
        end else begin
          stab_cnt <= stab_cnt + SW'(1);
        end
      end else begin
        stab_cnt <= '0;
      end
    end
  end

  // Movement outputs and pause toggle.
  // Both read the pre-toggle pause state on the edge where it flips.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      move_en <= 1'b0;
      facing  <= DIR_DOWN;
      paused  <= 1'b0;
    end else begin
      move_en <= dir_hit && !paused;
      if (dir_hit && !paused) begin
        facing <= dir_code;
      end
      if (press_pause) begin
        paused <= ~paused;
      end
    end
  end

  // Attack FSM: a single pulse per accepted Space press, then a cooldown
  // counted in unpaused frame ticks. Presses during the cooldown are dropped.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      atk_state    <= IDLE;
      cd_cnt       <= '0;
      attack_pulse <= 1'b0;
      attack_busy  <= 1'b0;
    end else begin
      attack_pulse <= 1'b0;
      case (atk_state)
        IDLE: begin
          // A frame tick arriving on this same edge is ignored, so the
          // freshly loaded count is never decremented here.
          if (press_attack && !paused) begin
            attack_pulse <= 1'b1;
            attack_busy  <= 1'b1;
            cd_cnt       <= CD_LOAD;
            atk_state    <= COOLDOWN;
          end
        end
        COOLDOWN: begin
          if (frame_tick && !paused) begin
            if (cd_cnt == CW'(1)) begin
              cd_cnt      <= '0;
              attack_busy <= 1'b0;
              atk_state   <= IDLE;
            end else begin
              cd_cnt <= cd_cnt - CW'(1);
            end
          end
        end
        default: begin
          cd_cnt      <= '0;
          attack_busy <= 1'b0;
          atk_state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keycode_action_ctrl.sv
// Directed testbench for keycode_action_ctrl.
// - Inputs are driven 1 time unit after a rising edge.
// - Outputs are sampled at that same point, well away from the next edge.
// - Every expected value below is worked out by hand, assuming default
//   parameters (STABLE_CYCLES=4, ATTACK_COOLDOWN=3).
module tb_keycode_action_ctrl;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] keycode = 8'h00;
  logic       frame_tick = 1'b0;
  logic [7:0] key_stable;
  logic       move_en;
  logic [1:0] facing;
  logic       attack_pulse;
  logic       attack_busy;
  logic       paused;

  int checks   = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  keycode_action_ctrl dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .keycode      (keycode),
    .frame_tick   (frame_tick),
    .key_stable   (key_stable),
    .move_en      (move_en),
    .facing       (facing),
    .attack_pulse (attack_pulse),
    .attack_busy  (attack_busy),
    .paused       (paused)
  );

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // Advance n edges, counting attack pulses seen after each edge.
  task automatic run(input int n, output int pulses);
    pulses = 0;
    repeat (n) begin
      @(posedge Clk);
      #1;
      if (attack_pulse) pulses++;
    end
  endtask

  // One frame tick, followed by an idle cycle.
  task automatic ftick();
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    step(1);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int p;
    int pulses;
    int pulse_at;
    int fall_at;
    logic glitch_seen;

    // ---------------------------------------------------------------
    // Reset, then idle with keycode = 0.
    // ---------------------------------------------------------------
    step(3);
    Reset = 1'b0;
    step(2);
    check("rst_key_stable", 32'(key_stable), 32'h00);
    check("rst_move_en", 32'(move_en), 0);
    check("rst_facing", 32'(facing), 32'h1);
    check("rst_attack_pulse", 32'(attack_pulse), 0);
    check("rst_attack_busy", 32'(attack_busy), 0);
    check("rst_paused", 32'(paused), 0);

    // ---------------------------------------------------------------
    // D held: key_stable updates exactly 5 edges after the change,
    // and move_en/facing follow one edge later.
    // ---------------------------------------------------------------
    keycode = 8'h07;
    step(4);
    check("d_ks_edge4", 32'(key_stable), 32'h00);
    step(1);
    check("d_ks_edge5", 32'(key_stable), 32'h07);
    check("d_move_edge5", 32'(move_en), 0);
    step(1);
    check("d_move_edge6", 32'(move_en), 1);
    check("d_facing_edge6", 32'(facing), 32'h3);
    step(3);

    // Release: move_en drops one edge after key_stable returns to 0.
    keycode = 8'h00;
    step(5);
    check("rel_ks", 32'(key_stable), 32'h00);
    check("rel_move_still", 32'(move_en), 1);
    step(1);
    check("rel_move_drop", 32'(move_en), 0);
    check("rel_facing_held", 32'(facing), 32'h3);

    // ---------------------------------------------------------------
    // 3-cycle glitch of W must never be accepted.
    // ---------------------------------------------------------------
    keycode = 8'h1A;
    step(3);
    keycode = 8'h00;
    glitch_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (key_stable != 8'h00 || move_en) glitch_seen = 1'b1;
    end
    check("glitch_rejected", 32'(glitch_seen), 0);
    check("glitch_facing", 32'(facing), 32'h3);

    // ---------------------------------------------------------------
    // Space held 40 cycles, with frame_tick driven before edges
    // 5, 10, 15, ...
    // - pulse after edge 7 (loop index 6),
    // - cooldown ticks land on edges 10, 15 and 20,
    // - so busy falls after edge 20 (loop index 19).
    // ---------------------------------------------------------------
    keycode  = 8'h2C;
    pulses   = 0;
    pulse_at = -1;
    fall_at  = -1;
    for (int i = 0; i < 40; i++) begin
      frame_tick = (i % 5 == 4);
      @(posedge Clk);
      #1;
      if (attack_pulse) begin
        pulses++;
        if (pulse_at < 0) pulse_at = i;
      end
      if (fall_at < 0 && pulse_at >= 0 && !attack_busy) fall_at = i;
    end
    frame_tick = 1'b0;
    check("atk_pulse_count", 32'(pulses), 1);
    check("atk_pulse_time", 32'(pulse_at), 6);
    check("atk_busy_fall", 32'(fall_at), 19);

    // Release then re-press after busy dropped: a second pulse.
    keycode = 8'h00;
    step(8);
    keycode = 8'h2C;
    run(10, p);
    check("atk_repress_pulse", 32'(p), 1);
    check("atk_repress_busy", 32'(attack_busy), 1);

    // Re-press while busy: discarded.
    keycode = 8'h00;
    step(8);
    keycode = 8'h2C;
    run(10, p);
    check("atk_busy_discard", 32'(p), 0);
    keycode = 8'h00;
    step(8);
    ftick();
    ftick();
    check("atk_busy_after2", 32'(attack_busy), 1);
    ftick();
    check("atk_busy_after3", 32'(attack_busy), 0);

    // ---------------------------------------------------------------
    // Pause behaviour.
    // ---------------------------------------------------------------
    keycode = 8'h28;
    run(8, p);
    check("pause_on", 32'(paused), 1);
    keycode = 8'h00;
    step(8);
    check("pause_release_hold", 32'(paused), 1);

    // A held direction while paused: no movement, facing stays right.
    keycode = 8'h04;
    step(8);
    check("pause_ks_left", 32'(key_stable), 32'h04);
    check("pause_move_off", 32'(move_en), 0);
    check("pause_facing_held", 32'(facing), 32'h3);

    // Space while paused: no pulse.
    keycode = 8'h2C;
    run(10, p);
    check("pause_no_attack", 32'(p), 0);
    check("pause_no_busy", 32'(attack_busy), 0);
    keycode = 8'h00;
    step(8);

    // Enter again: unpause, then movement resumes once A is accepted.
    keycode = 8'h28;
    step(8);
    check("pause_off", 32'(paused), 0);
    keycode = 8'h00;
    step(8);
    keycode = 8'h04;
    step(5);
    check("unpause_move_edge5", 32'(move_en), 0);
    step(1);
    check("unpause_move_edge6", 32'(move_en), 1);
    check("unpause_facing", 32'(facing), 32'h2);
    keycode = 8'h00;
    step(8);

    // ---------------------------------------------------------------
    // Cooldown freezes while paused.
    // ---------------------------------------------------------------
    keycode = 8'h2C;
    run(8, p);
    check("frz_pulse", 32'(p), 1);
    keycode = 8'h00;
    step(8);
    ftick();                 // count 3 -> 2
    keycode = 8'h28;
    step(8);
    check("frz_paused", 32'(paused), 1);
    keycode = 8'h00;
    step(8);
    repeat (4) ftick();      // ignored while paused
    check("frz_busy_paused", 32'(attack_busy), 1);
    keycode = 8'h28;
    step(8);
    check("frz_unpaused", 32'(paused), 0);
    keycode = 8'h00;
    step(8);
    ftick();                 // count 2 -> 1
    check("frz_busy_tick1", 32'(attack_busy), 1);
    frame_tick = 1'b1;
    step(1);                 // count 1 -> idle
    frame_tick = 1'b0;
    check("frz_busy_tick2", 32'(attack_busy), 0);
    step(1);

    // ---------------------------------------------------------------
    // Attack press and frame_tick on the same edge: the tick is ignored,
    // so busy is still high after two further ticks.
    // ---------------------------------------------------------------
    keycode = 8'h2C;
    step(6);
    frame_tick = 1'b1;
    step(1);                 // edge 7: pulse fires
    frame_tick = 1'b0;
    check("coinc_pulse", 32'(attack_pulse), 1);
    keycode = 8'h00;
    step(8);
    ftick();
    ftick();
    check("coinc_busy", 32'(attack_busy), 1);

    // ---------------------------------------------------------------
    // Reset asserted during the cooldown.
    // ---------------------------------------------------------------
    Reset = 1'b1;
    step(1);
    check("midrst_busy", 32'(attack_busy), 0);
    check("midrst_facing", 32'(facing), 32'h1);
    Reset = 1'b0;
    step(6);
    check("midrst_ks", 32'(key_stable), 32'h00);
    check("midrst_busy_stays", 32'(attack_busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
